// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Operands are registered onto the ALU, MUL gets extra settle cycles, and a tagged result is returned with valid/ready.
module alu_share_arbiter #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][5:0]        req_opcode,
    input  logic [1:0][5:0]        req_ar_op,
    input  logic [1:0][4:0]        req_shamt,
    input  logic [1:0][DATA_W-1:0] req_op1,
    input  logic [1:0][DATA_W-1:0] req_op2,
    output logic [DATA_W-1:0]      alu_op1,
    output logic [DATA_W-1:0]      alu_op2,
    output logic [5:0]             alu_opcode,
    output logic [5:0]             alu_ar_op,
    output logic [4:0]             alu_shamt,
    input  logic [DATA_W-1:0]      alu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_id,
    output logic                   busy
);

    localparam logic [5:0] OP_MUL  = 6'b011100;
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_last_grant;
    logic [DATA_W-1:0]   r_alu_op1;
    logic [DATA_W-1:0]   r_alu_op2;
    logic [5:0]          r_alu_opcode;
    logic [5:0]          r_alu_ar_op;
    logic [4:0]          r_alu_shamt;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_id;

    logic [1:0]          w_ready;
    logic                w_sel;
    logic                w_xfer;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        w_ready = 2'b00;
        w_sel   = 1'b0;
        if (r_state == IDLE && !flush) begin
            case (req_valid)
                2'b01: begin
                    w_ready = 2'b01;
                    w_sel   = 1'b0;
                end
                2'b10: begin
                    w_ready = 2'b10;
                    w_sel   = 1'b1;
                end
                2'b11: begin
                    w_sel   = ~r_last_grant;
                    w_ready = r_last_grant ? 2'b01 : 2'b10;
                end
                default: begin
                    w_ready = 2'b00;
                    w_sel   = 1'b0;
                end
            endcase
        end
    end

    assign w_xfer    = |(req_valid & w_ready);
    assign req_ready = w_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_alu_opcode <= 6'd0;
            r_alu_ar_op  <= 6'd0;
            r_alu_shamt  <= 5'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_id     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_alu_op1    <= req_op1[w_sel];
                        r_alu_op2    <= req_op2[w_sel];
                        r_alu_opcode <= req_opcode[w_sel];
                        r_alu_ar_op  <= req_ar_op[w_sel];
                        r_alu_shamt  <= req_shamt[w_sel];
                        r_rsp_id     <= w_sel;
                        r_last_grant <= w_sel;
                        r_cnt        <= (req_opcode[w_sel] == OP_MUL) ? MUL_CNT : 4'd0;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    // A flushed operation simply disappears; no response is produced.
                    if (flush) begin
                        r_state <= IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rsp_data  <= alu_result;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (flush || rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign alu_op1    = r_alu_op1;
    assign alu_op2    = r_alu_op2;
    assign alu_opcode = r_alu_opcode;
    assign alu_ar_op  = r_alu_ar_op;
    assign alu_shamt  = r_alu_shamt;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_rsp_id;
    assign busy       = (r_state != IDLE);

endmodule
